// File: rtl/mdu_pkg.sv
// Shared constants and types for the multicycle multiply/divide unit.
// Optional feature macro: DIVZERO_EXC_EN (divide-by-zero early exit and flag).
package mdu_pkg;

    localparam int unsigned MDU_WIDTH = 32;
    localparam int unsigned ITER      = MDU_WIDTH;
    localparam int unsigned CNT_W     = $clog2(ITER);

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mdu_if.sv
// Request/result bundle between the control path (master) and the mult/div unit (slave).
// Signals: start/op/a/b requests; hi/lo results; busy/done status.
// div_zero is present only when DIVZERO_EXC_EN is defined.
interface mdu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
`ifdef DIVZERO_EXC_EN
    logic             div_zero;

    modport master (output start, op, a, b, input hi, lo, busy, done, div_zero);
    modport slave  (input start, op, a, b, output hi, lo, busy, done, div_zero);
`else
    modport master (output start, op, a, b, input hi, lo, busy, done);
    modport slave  (input start, op, a, b, output hi, lo, busy, done);
`endif
endinterface

// File: rtl/mdu_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// Ports: rq_i = {remainder, quotient/dividend-bits}, divisor_i, rq_o = next {rem, quo}.
module mdu_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] rq_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH-1:0] rq_o
);
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    // Shift in the next dividend bit, try the subtraction, keep it if no borrow.
    always_comb begin
        rem_sh = rq_i[2*WIDTH-1:WIDTH-1];
        trial  = rem_sh - {1'b0, divisor_i};
        if (!trial[WIDTH]) begin
            rq_o = {trial[WIDTH-1:0], rq_i[WIDTH-2:0], 1'b1};
        end else begin
            rq_o = {rem_sh[WIDTH-1:0], rq_i[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT (shift-add) / DIV (restoring) unit producing HI/LO.
// Ports: clk, reset (async, active-high), bus (mdu_if.slave: start/op/a/b in,
// hi/lo/busy/done out, plus div_zero when DIVZERO_EXC_EN is defined).
// Both operations work on magnitudes; signs are applied in the FIX state.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = ITER
) (
    input  logic clk,
    input  logic reset,
    mdu_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned W2 = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             op_q, op_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;
    logic             bz_q, bz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef DIVZERO_EXC_EN
    logic             dz_q, dz_d;
`endif

    logic             a_neg, b_neg, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [W2-1:0]    mul_next, div_next, prod_neg;
    logic [WIDTH-1:0] quo, rem, quo_neg, rem_neg;

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rq_i      (acc_q),
        .divisor_i (opnd_q),
        .rq_o      (div_next)
    );

    // Operand magnitudes, shift-add step and sign fix-up values.
    always_comb begin
        a_neg    = bus.a[WIDTH-1];
        b_neg    = bus.b[WIDTH-1];
        b_zero   = (bus.b == '0);
        a_mag    = a_neg ? (~bus.a + WIDTH'(1)) : bus.a;
        b_mag    = b_neg ? (~bus.b + WIDTH'(1)) : bus.b;
        mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
        prod_neg = ~acc_q + W2'(1);
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[W2-1:WIDTH];
        quo_neg  = ~quo + WIDTH'(1);
        rem_neg  = ~rem + WIDTH'(1);
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        bz_d      = bz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef DIVZERO_EXC_EN
        dz_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d      = bus.op;
                    bz_d      = b_zero;
                    neg_d     = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    // Multiplier rides in the low half; dividend likewise for division.
                    if (bus.op == OP_MULT) begin
                        opnd_d = a_mag;
                        acc_d  = {WIDTH'(0), b_mag};
                    end else begin
                        opnd_d = b_mag;
                        acc_d  = {WIDTH'(0), a_mag};
                    end
                    state_d = ST_RUN;
`ifdef DIVZERO_EXC_EN
                    if (bus.op == OP_DIV && b_zero) begin
                        state_d = ST_FIX;
                    end
`endif
                end
            end
            ST_RUN: begin
                acc_d = (op_q == OP_MULT) ? mul_next : div_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
`ifdef DIVZERO_EXC_EN
                if (op_q == OP_DIV && bz_q) begin
                    dz_d = 1'b1;
                end else
`endif
                begin
                    if (op_q == OP_MULT) begin
                        {hi_d, lo_d} = neg_q ? prod_neg : acc_q;
                    end else begin
                        // Zero divisor leaves the all-ones quotient unsigned.
                        lo_d = (neg_q && !bz_q) ? quo_neg : quo;
                        hi_d = neg_rem_q ? rem_neg : rem;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            bz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef DIVZERO_EXC_EN
            dz_q      <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            bz_q      <= bz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef DIVZERO_EXC_EN
            dz_q      <= dz_d;
`endif
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
`ifdef DIVZERO_EXC_EN
    assign bus.div_zero = dz_q;
`endif
endmodule
